// File: rtl/tmds_dec.sv
// rtl/tmds_dec.sv - single-lane TMDS decoder with control-token word alignment (optional stats: TMDS_DEC_STAT_EN)
module tmds_dec #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] tmds_d_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
`ifdef TMDS_DEC_STAT_EN
    ,
    output logic [7:0] slip_cnt_o,
    output logic [7:0] loss_cnt_o
`endif
);

    localparam int RW = $clog2(CTRL_RUN + 1);

    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

    state_t        state, state_n;
    logic [RW-1:0] run_cnt, run_cnt_n;
    logic [15:0]   tmr, tmr_n;
    logic          is_tok;
    logic [1:0]    tok_ctrl;
    logic [7:0]    v;
    logic [7:0]    dec;

    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (tmds_d_i)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: is_tok   = 1'b0;
        endcase
    end

    // Undo the transmit-side XOR/XNOR chain after optional inversion.
    always_comb begin
        v      = tmds_d_i[9] ? ~tmds_d_i[7:0] : tmds_d_i[7:0];
        dec    = 8'h00;
        dec[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = tmds_d_i[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
    end

    always_comb begin
        state_n   = state;
        run_cnt_n = run_cnt;
        tmr_n     = tmr + 16'd1;
        case (state)
            SEARCH: begin
                if (is_tok) begin
                    run_cnt_n = run_cnt + 1'b1;
                    if (run_cnt == RW'(CTRL_RUN - 1)) state_n = LOCKED;
                end else begin
                    run_cnt_n = '0;
                end
                if (state_n == SEARCH && tmr == 16'(SEARCH_TIMEOUT - 1)) state_n = SLIP;
            end
            SLIP: state_n = WAIT;
            WAIT: begin
                if (tmr == 16'(SLIP_WAIT - 1)) state_n = SEARCH;
            end
            LOCKED: begin
                if (is_tok) tmr_n = '0;
                else if (tmr == 16'(LOSS_TIMEOUT - 1)) state_n = SEARCH;
            end
            default: state_n = SEARCH;
        endcase
        if (state_n != state) tmr_n = '0;
        if (state_n != SEARCH) run_cnt_n = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SEARCH;
            run_cnt   <= '0;
            tmr       <= '0;
            bitslip_o <= 1'b0;
            locked_o  <= 1'b0;
            de_o      <= 1'b0;
            ctrl_o    <= 2'b00;
            data_o    <= 8'h00;
        end else begin
            state     <= state_n;
            run_cnt   <= run_cnt_n;
            tmr       <= tmr_n;
            bitslip_o <= (state_n == SLIP);
            locked_o  <= (state_n == LOCKED);
            // Decode follows next-state so the locking token is the first valid output.
            if (state_n == LOCKED) begin
                if (is_tok) begin
                    de_o   <= 1'b0;
                    ctrl_o <= tok_ctrl;
                    data_o <= 8'h00;
                end else begin
                    de_o   <= 1'b1;
                    data_o <= dec;
                end
            end else begin
                de_o   <= 1'b0;
                ctrl_o <= 2'b00;
                data_o <= 8'h00;
            end
        end
    end

`ifdef TMDS_DEC_STAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slip_cnt_o <= 8'h00;
            loss_cnt_o <= 8'h00;
        end else begin
            if (state_n == SLIP && state != SLIP && slip_cnt_o != 8'hFF)
                slip_cnt_o <= slip_cnt_o + 8'd1;
            if (state == LOCKED && state_n == SEARCH && loss_cnt_o != 8'hFF)
                loss_cnt_o <= loss_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_dec.sv
// tb/tb_tmds_dec.sv - self-checking bench for tmds_dec
module tb_tmds_dec;

    localparam int GAP = 4096 + 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] tmds_d_i = 10'h000;
    logic       bitslip_o, locked_o, de_o;
    logic [1:0] ctrl_o;
    logic [7:0] data_o;
`ifdef TMDS_DEC_STAT_EN
    logic [7:0] slip_cnt_o, loss_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] exp_q[$];
    bit          chk_q[$];
    string       tag_q[$];

    tmds_dec dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .tmds_d_i  (tmds_d_i),
        .bitslip_o (bitslip_o),
        .locked_o  (locked_o),
        .de_o      (de_o),
        .ctrl_o    (ctrl_o),
        .data_o    (data_o)
`ifdef TMDS_DEC_STAT_EN
        ,
        .slip_cnt_o(slip_cnt_o),
        .loss_cnt_o(loss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ex(input logic lk, input logic de, input logic [1:0] c, input logic [7:0] d);
        return {1'b0, lk, de, c, d};
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] dbl;
        dbl = {w, w};
        return dbl[k +: 10];
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        logic [12:0] e;
        bit          c;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            t = tag_q.pop_front();
            if (c) check(t, {bitslip_o, locked_o, de_o, ctrl_o, data_o}, e);
        end
    endtask

    task automatic step(input logic r, input logic [9:0] w, input bit c, input logic [12:0] e, input string tag);
        @(negedge clk);
        pop_check();
        rst_i    = r;
        tmds_d_i = w;
        exp_q.push_back(e);
        chk_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        @(negedge clk);
        pop_check();
    endtask

    initial begin
        int off, pulses, last, cyc;

        for (int i = 0; i < 3; i++) step(1'b1, 10'($urandom), 1'b1, 13'h0, "reset");

        for (int i = 0; i < 7; i++) step(1'b0, 10'h354, 1'b1, 13'h0, "pre_lock");
        step(1'b0, 10'h354, 1'b1, ex(1, 0, 2'b00, 8'h00), "lock8");
        step(1'b0, 10'h100, 1'b1, ex(1, 1, 2'b00, 8'h00), "data_100");
        step(1'b0, 10'h1FF, 1'b1, ex(1, 1, 2'b00, 8'h01), "data_1ff");
        step(1'b0, 10'h0AB, 1'b1, ex(1, 0, 2'b01, 8'h00), "ctrl_01");
        step(1'b0, 10'h2AB, 1'b1, ex(1, 0, 2'b11, 8'h00), "ctrl_11");
        step(1'b0, 10'h2F0, 1'b1, ex(1, 1, 2'b11, 8'hEF), "data_2f0");
        step(1'b0, 10'h154, 1'b1, ex(1, 0, 2'b10, 8'h00), "ctrl_10");

        for (int i = 0; i < 4095; i++) step(1'b0, 10'h100, 1'b1, ex(1, 1, 2'b10, 8'h00), "locked_hold");
        step(1'b0, 10'h100, 1'b1, 13'h0, "loss");
        flush();
`ifdef TMDS_DEC_STAT_EN
        check("loss_cnt", {5'b0, loss_cnt_o}, 13'd1);
`endif

        for (int i = 0; i < 7; i++) step(1'b0, 10'h354, 1'b1, 13'h0, "run_a");
        step(1'b0, 10'h100, 1'b1, 13'h0, "run_break");
        for (int i = 0; i < 7; i++) step(1'b0, 10'h354, 1'b1, 13'h0, "run_b");
        step(1'b0, 10'h354, 1'b1, ex(1, 0, 2'b00, 8'h00), "relock");
        step(1'b1, 10'h100, 1'b1, 13'h0, "rst_locked");
        flush();

        off = 3; pulses = 0; last = -1; cyc = 0;
        while (!locked_o && cyc < 60000) begin
            @(negedge clk);
            rst_i = 1'b0;
            if (bitslip_o) begin
                pulses++;
                if (last >= 0) check("slip_gap", {12'b0, (cyc - last) >= GAP}, 13'd1);
                last = cyc;
                off  = (off + 1) % 10;
            end
            tmds_d_i = rot(10'h354, off);
            cyc++;
        end
        check("misalign_lock", {12'b0, locked_o}, 13'd1);
        check("slip_pulses", 13'(pulses), 13'd7);
`ifdef TMDS_DEC_STAT_EN
        check("slip_cnt", {5'b0, slip_cnt_o}, 13'd7);
`endif

        cyc = 0;
        while (!bitslip_o && cyc < 20000) begin
            @(negedge clk);
            tmds_d_i = 10'h100;
            cyc++;
        end
        check("wait_slip_seen", {12'b0, bitslip_o}, 13'd1);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_wait", {bitslip_o, locked_o, de_o, ctrl_o, data_o}, 13'h0);
`ifdef TMDS_DEC_STAT_EN
        check("rst_stats", {slip_cnt_o, loss_cnt_o[4:0]}, 13'h0);
`endif
        for (int i = 0; i < 7; i++) step(1'b0, 10'h354, 1'b1, 13'h0, "post_rst_run");
        step(1'b0, 10'h354, 1'b1, ex(1, 0, 2'b00, 8'h00), "post_rst_lock");
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
